// File: rtl/regfile_scoreboard.sv
// Register file with a per-register busy scoreboard.
// Two combinational read ports (optionally bypassed from the same-cycle
// writeback), a raw debug read port, issue-time reservations that mark a
// destination busy, and writeback that stores data and releases the
// reservation. busy_count tracks how many registers are currently busy.
module regfile_scoreboard #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    localparam int AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic            Clk,
    input  logic            Reset_n,
    // writeback
    input  logic            Load,
    input  logic [AW-1:0]   addrD,
    input  logic [XLEN-1:0] D,
    // read ports
    input  logic [AW-1:0]   addrA,
    input  logic [AW-1:0]   addrB,
    output logic [XLEN-1:0] dataA,
    output logic [XLEN-1:0] dataB,
    // reservation / hazard interface
    input  logic            Reserve,
    input  logic [AW-1:0]   addrR,
    output logic            busyA,
    output logic            busyB,
    output logic            busyR,
    output logic [AW:0]     busy_count,
    // debug read port
    input  logic [AW-1:0]   addrDbg,
    output logic [XLEN-1:0] dataDbg
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [XLEN-1:0] regs_q [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [AW:0]      busy_count_q;
    logic [AW:0]      busy_count_d;

    // Qualified write and reserve enables (zero register filtered out)
    logic wr_en;
    logic rsv_en;
    // Busy-count transition terms for this edge
    logic cnt_inc;
    logic cnt_dec;

    // True when the address names the hardwired zero register
    function automatic logic is_zero_reg(input logic [AW-1:0] a);
        return (ZERO_REG == 1'b1) && (a == '0);
    endfunction

    // Read-port data: zero register, then bypass, then stored value.
    // Reset forces zero so a pending writeback cannot leak through bypass.
    function automatic logic [XLEN-1:0] read_data(input logic [AW-1:0] a);
        logic [XLEN-1:0] r;
        r = regs_q[a];
        if (!Reset_n || is_zero_reg(a)) begin
            r = '0;
        end else if ((BYPASS == 1'b1) && Load && (addrD == a)) begin
            r = D;
        end
        return r;
    endfunction

    // Read-port busy: a writeback releasing this register this cycle reads
    // as not busy, unless a new producer reserves the same register now.
    function automatic logic read_busy(input logic [AW-1:0] a);
        logic r;
        r = busy_q[a];
        if (!Reset_n || is_zero_reg(a)) begin
            r = 1'b0;
        end else if ((BYPASS == 1'b1) && Load && (addrD == a) &&
                     !(rsv_en && (addrR == a))) begin
            r = 1'b0;
        end
        return r;
    endfunction

    // Writes to the zero register are dropped; reservations of it ignored
    always_comb begin
        wr_en  = Load && !is_zero_reg(addrD);
        rsv_en = Reserve && !is_zero_reg(addrR);
    end

    // Register array update on writeback
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[addrD] <= D;
        end
    end

    // Next busy vector: clear on writeback, then set on reserve so that a
    // same-register reserve wins over the release
    always_comb begin
        busy_d = busy_q;
        if (Load) begin
            busy_d[addrD] = 1'b0;
        end
        if (rsv_en) begin
            busy_d[addrR] = 1'b1;
        end
    end

    // Incremental population count: +1 on a 0->1 bit, -1 on a 1->0 bit
    always_comb begin
        cnt_inc      = rsv_en && !busy_q[addrR];
        cnt_dec      = Load && busy_q[addrD] && !(rsv_en && (addrR == addrD));
        busy_count_d = busy_count_q;
        if (cnt_inc && !cnt_dec) begin
            busy_count_d = busy_count_q + 1'b1;
        end else if (cnt_dec && !cnt_inc) begin
            busy_count_d = busy_count_q - 1'b1;
        end
    end

    // Busy bits and their count move together on the same edge
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    // Combinational read, busy and debug outputs
    always_comb begin
        dataA      = read_data(addrA);
        dataB      = read_data(addrB);
        busyA      = read_busy(addrA);
        busyB      = read_busy(addrB);
        // WAW indication reflects only the stored scoreboard state
        busyR      = Reset_n ? busy_q[addrR] : 1'b0;
        busy_count = busy_count_q;
        // Debug port shows the raw stored value, never the bypass
        dataDbg    = (!Reset_n || is_zero_reg(addrDbg)) ? '0 : regs_q[addrDbg];
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: one instance with bypass and one without,
// sharing all inputs, checked against a behavioural array model.
module tb_regfile_scoreboard;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared inputs ----------------
  logic            load;
  logic [AW-1:0]   addr_d;
  logic [XLEN-1:0] d;
  logic [AW-1:0]   addr_a;
  logic [AW-1:0]   addr_b;
  logic            reserve;
  logic [AW-1:0]   addr_r;
  logic [AW-1:0]   addr_dbg;

  // ---------------- outputs, bypass instance ----------------
  logic [XLEN-1:0] byp_data_a, byp_data_b, byp_data_dbg;
  logic            byp_busy_a, byp_busy_b, byp_busy_r;
  logic [AW:0]     byp_busy_count;

  // ---------------- outputs, non-bypass instance ----------------
  logic [XLEN-1:0] nob_data_a, nob_data_b, nob_data_dbg;
  logic            nob_busy_a, nob_busy_b, nob_busy_r;
  logic [AW:0]     nob_busy_count;

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut_byp (
    .Clk(clk), .Reset_n(rst_n),
    .Load(load), .addrD(addr_d), .D(d),
    .addrA(addr_a), .addrB(addr_b), .dataA(byp_data_a), .dataB(byp_data_b),
    .Reserve(reserve), .addrR(addr_r),
    .busyA(byp_busy_a), .busyB(byp_busy_b), .busyR(byp_busy_r),
    .busy_count(byp_busy_count),
    .addrDbg(addr_dbg), .dataDbg(byp_data_dbg)
  );

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_dut_nob (
    .Clk(clk), .Reset_n(rst_n),
    .Load(load), .addrD(addr_d), .D(d),
    .addrA(addr_a), .addrB(addr_b), .dataA(nob_data_a), .dataB(nob_data_b),
    .Reserve(reserve), .addrR(addr_r),
    .busyA(nob_busy_a), .busyB(nob_busy_b), .busyR(nob_busy_r),
    .busy_count(nob_busy_count),
    .addrDbg(addr_dbg), .dataDbg(nob_data_dbg)
  );

  // ---------------- reference model ----------------
  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREGS; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  function automatic int model_count();
    int c;
    c = 0;
    for (int i = 0; i < NREGS; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic logic [XLEN-1:0] exp_data(input int a, input bit byp);
    if (!rst_n || a == 0) return '0;
    if (byp && load && int'(addr_d) == a) return d;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input int a, input bit byp);
    if (!rst_n || a == 0) return 1'b0;
    if (byp && load && int'(addr_d) == a && !(reserve && int'(addr_r) == a)) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic [XLEN-1:0] exp_dbg(input int a);
    if (!rst_n || a == 0) return '0;
    return m_regs[a];
  endfunction

  // Clock edge effect of the current inputs on the model
  task automatic model_edge();
    if (!rst_n) return;
    if (load && addr_d != 0) m_regs[addr_d] = d;
    if (load) m_busy[addr_d] = 1'b0;
    if (reserve && addr_r != 0) m_busy[addr_r] = 1'b1;
  endtask

  task automatic compare_all();
    check("byp_dataA",  byp_data_a,            exp_data(int'(addr_a), 1'b1));
    check("byp_dataB",  byp_data_b,            exp_data(int'(addr_b), 1'b1));
    check("byp_busyA",  32'(byp_busy_a),       32'(exp_busy(int'(addr_a), 1'b1)));
    check("byp_busyB",  32'(byp_busy_b),       32'(exp_busy(int'(addr_b), 1'b1)));
    check("byp_busyR",  32'(byp_busy_r),       rst_n ? 32'(m_busy[addr_r]) : 32'd0);
    check("byp_count",  32'(byp_busy_count),   32'(model_count()));
    check("byp_dbg",    byp_data_dbg,          exp_dbg(int'(addr_dbg)));
    check("nob_dataA",  nob_data_a,            exp_data(int'(addr_a), 1'b0));
    check("nob_dataB",  nob_data_b,            exp_data(int'(addr_b), 1'b0));
    check("nob_busyA",  32'(nob_busy_a),       32'(exp_busy(int'(addr_a), 1'b0)));
    check("nob_busyB",  32'(nob_busy_b),       32'(exp_busy(int'(addr_b), 1'b0)));
    check("nob_busyR",  32'(nob_busy_r),       rst_n ? 32'(m_busy[addr_r]) : 32'd0);
    check("nob_count",  32'(nob_busy_count),   32'(model_count()));
    check("nob_dbg",    nob_data_dbg,          exp_dbg(int'(addr_dbg)));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic ld, input int ad, input logic [XLEN-1:0] dv,
                       input logic rs, input int ar, input int aa, input int ab, input int adbg);
    load     = ld;
    addr_d   = AW'(ad);
    d        = dv;
    reserve  = rs;
    addr_r   = AW'(ar);
    addr_a   = AW'(aa);
    addr_b   = AW'(ab);
    addr_dbg = AW'(adbg);
  endtask

  task automatic idle();
    drive(1'b0, 0, '0, 1'b0, 0, 0, 0, 0);
  endtask

  // Mid-cycle: compare every output with the model
  task automatic half();
    @(negedge clk);
    compare_all();
  endtask

  // Rising edge: advance the model, then step off the edge
  task automatic edge_step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cycle();
    half();
    edge_step();
  endtask

  function automatic int rand_addr();
    if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 7));
    return int'($urandom_range(0, NREGS - 1));
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    model_clear();
    idle();

    // Reset state, before any clock edge
    #2;
    compare_all();
    check("rst_count0", 32'(byp_busy_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    edge_step();

    // Same-cycle bypass of a writeback to r5
    drive(1'b1, 5, 32'h1234_5678, 1'b0, 0, 5, 5, 5);
    half();
    check("wr5_byp_dataA", byp_data_a, 32'h1234_5678);
    check("wr5_nob_old",   nob_data_a, 32'h0);
    check("wr5_dbg_raw",   byp_data_dbg, 32'h0);
    edge_step();
    drive(1'b0, 0, '0, 1'b0, 0, 5, 5, 5);
    half();
    check("wr5_nob_new", nob_data_a, 32'h1234_5678);
    edge_step();

    // Zero register: write dropped, reserve ignored
    drive(1'b1, 0, 32'hFFFF_FFFF, 1'b1, 0, 0, 0, 0);
    half();
    check("z_dataA", byp_data_a, 32'h0);
    check("z_busyA", 32'(byp_busy_a), 32'd0);
    edge_step();
    drive(1'b0, 0, '0, 1'b0, 0, 0, 0, 0);
    half();
    check("z_count", 32'(byp_busy_count), 32'd0);
    check("z_dbg",   byp_data_dbg, 32'h0);
    edge_step();

    // Reserve r7, then release it through writeback
    drive(1'b0, 0, '0, 1'b1, 7, 7, 7, 7);
    cycle();
    drive(1'b0, 0, '0, 1'b0, 7, 7, 7, 7);
    half();
    check("r7_busyA", 32'(byp_busy_a), 32'd1);
    check("r7_count", 32'(byp_busy_count), 32'd1);
    edge_step();
    drive(1'b1, 7, 32'h0000_0777, 1'b0, 7, 7, 7, 7);
    half();
    check("r7_byp_release", 32'(byp_busy_a), 32'd0);
    check("r7_nob_still",   32'(nob_busy_a), 32'd1);
    check("r7_busyR",       32'(byp_busy_r), 32'd1);
    edge_step();
    idle();
    half();
    check("r7_count0", 32'(byp_busy_count), 32'd0);
    edge_step();

    // Reserve and load the same busy register: reserve wins
    drive(1'b0, 0, '0, 1'b1, 9, 9, 9, 9);
    cycle();
    drive(1'b1, 9, 32'hCAFE_F00D, 1'b1, 9, 9, 9, 9);
    half();
    check("r9_busyR", 32'(byp_busy_r), 32'd1);
    check("r9_busyA", 32'(byp_busy_a), 32'd1);
    edge_step();
    drive(1'b0, 0, '0, 1'b0, 9, 9, 9, 9);
    half();
    check("r9_dbg",   byp_data_dbg, 32'hCAFE_F00D);
    check("r9_busy",  32'(nob_busy_a), 32'd1);
    check("r9_count", 32'(byp_busy_count), 32'd1);
    edge_step();
    drive(1'b1, 9, 32'hCAFE_F00D, 1'b0, 0, 9, 9, 9);
    cycle();

    // Reserve all non-zero registers
    for (int i = 1; i < NREGS; i++) begin
      drive(1'b0, 0, '0, 1'b1, i, i, 0, i);
      cycle();
    end
    idle();
    half();
    check("all_count31", 32'(byp_busy_count), 32'd31);
    edge_step();
    drive(1'b1, 4, 32'h4444_4444, 1'b1, 3, 3, 4, 4);
    half();
    check("waw_busyR", 32'(byp_busy_r), 32'd1);
    edge_step();
    idle();
    half();
    check("waw_count30", 32'(byp_busy_count), 32'd30);
    edge_step();

    // Fill r1..r31, each reserved in the same cycle, then async reset mid-cycle
    for (int i = 1; i < NREGS; i++) begin
      drive(1'b1, i, 32'hA5A5_0000 + 32'(i), 1'b1, i, i, i - 1, i);
      cycle();
    end
    idle();
    half();
    check("pre_rst_count", 32'(byp_busy_count), 32'd31);
    check("pre_rst_r17",   byp_data_dbg, 32'h0);
    addr_dbg = AW'(17);
    #1;
    check("pre_rst_dbg17", byp_data_dbg, 32'hA5A5_0011);
    rst_n = 1'b0;
    model_clear();
    #1;
    check("rst_async_count", 32'(byp_busy_count), 32'd0);
    check("rst_async_dbg17", byp_data_dbg, 32'h0);
    for (int i = 0; i < NREGS; i++) begin
      drive(1'b1, i, 32'hDEAD_BEEF, 1'b1, i, i, NREGS - 1 - i, i);
      #0.1;
      compare_all();
    end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    half();
    edge_step();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      drive(1'($urandom_range(0, 1)), rand_addr(), $urandom(),
            1'($urandom_range(0, 1)), rand_addr(),
            rand_addr(), rand_addr(), rand_addr());
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised general-purpose register file for the RISC-V core, with a per-register busy scoreboard.
- Two combinational read ports with optional write-to-read bypass.
- Hardwired zero register.
- Decode reserves a destination at issue; writeback writes the data and releases the reservation.
- Busy outputs feed the hazard/stall logic. A debug read port feeds the board display.

Parameters:
XLEN, 32, data width of each register.
NREGS, 32, number of registers; power of two, >= 2.
AW, $clog2(NREGS), address width (derived, not overridden).
ZERO_REG, 1, if 1 register 0 reads 0, ignores writes, and is never busy.
BYPASS, 1, if 1 a same-cycle write is forwarded to the read ports and busy flags.

Ports:
Clk  in  1  clock, all state updates on rising edge.
Reset_n  in  1  asynchronous active-low reset.
Load  in  1  writeback enable.
addrD  in  AW  writeback destination.
D  in  XLEN  writeback data.
addrA  in  AW  read port A address.
addrB  in  AW  read port B address.
dataA  out  XLEN  read port A data.
dataB  out  XLEN  read port B data.
Reserve  in  1  issue-time reservation enable.
addrR  in  AW  register to reserve.
busyA  out  1  register addrA has a pending write.
busyB  out  1  register addrB has a pending write.
busyR  out  1  register addrR already has a pending write (WAW indication).
busy_count  out  AW+1  number of registers currently busy.
addrDbg  in  AW  debug read address.
dataDbg  out  XLEN  debug read data, never bypassed.

Behaviour:
Reset:
- Reset_n low asynchronously clears every register, every busy bit and busy_count to 0, independent of Clk.
- While low: dataA/dataB/dataDbg = 0, busyA/busyB/busyR = 0.
- Deassertion takes effect on the next rising edge; no partial update in the edge where reset releases.

Write (rising edge, Load=1):
- reg[addrD] <= D.
- If ZERO_REG=1 and addrD=0, the write is dropped.

Read (combinational, zero latency):
- dataX = reg[addrX].
- If ZERO_REG=1 and addrX=0: dataX = 0, busyX = 0.
- If BYPASS=1, Load=1, addrD=addrX, and addrX is not the zero register: dataX = D.
- If BYPASS=0, the new value is visible the cycle after the edge.

Scoreboard, per-register busy bit, rising edge:
- Reserve=1 sets busy[addrR]. Ignored for the zero register when ZERO_REG=1.
- Load=1 clears busy[addrD].
- Reserve and Load to the same register in the same cycle: Reserve wins, the bit ends set (new producer issued).
- Reserve to an already-busy register: bit stays set, busyR=1 that cycle. It is single-bit, not counted.
- Load to a non-busy register: data written, busy unchanged, no error.

Busy outputs:
- busyX = busy[addrX].
- If BYPASS=1 and this cycle's Load clears addrX (addrD=addrX, no same-register Reserve): busyX = 0.
- busyR never bypassed.

busy_count:
- Registered population count of busy bits, updated in the same edge as the bits.
- Increments on a 0->1 transition, decrements on 1->0, unchanged when both or neither occur.
- Range 0..NREGS; cannot wrap.

Debug port:
- dataDbg = reg[addrDbg], raw stored value.
- No bypass; the zero register still reads 0.

Test Plan:
- Reset_n pulsed low mid-cycle after registers 1..31 written with 0xA5A5_0000+i -> all reads 0 and busy_count=0 immediately, without a clock edge.
- Load=1, addrD=5, D=0x1234_5678, addrA=5, BYPASS=1 -> dataA=0x1234_5678 in the same cycle. With BYPASS=0 -> old value this cycle, new value next cycle.
- Load=1, addrD=0, D=0xFFFF_FFFF, then addrA=0 -> dataA=0. Reserve with addrR=0 -> busy_count stays 0 and busyA stays 0.
- Reserve addrR=7 -> next cycle busyA=1 (addrA=7), busy_count=1. Then Load addrD=7 with addrA=7 -> busyA=0 combinationally; next cycle busy_count=0.
- Same cycle Reserve addrR=9 and Load addrD=9, reg 9 already busy -> reg 9 gets D, busy stays 1, busy_count unchanged.
- Reserve all 31 non-zero registers over 31 cycles -> busy_count=31. Then simultaneous Reserve of busy reg 3 and Load to reg 4 -> busyR=1, busy_count=30.
